addertree_accum: RTL and testbench



---
 rtl/addertree_accum_if.sv | 35 +++
 rtl/addertree_accum.sv | 131 +++++++++++++
 tb/tb_addertree_accum.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/addertree_accum_if.sv
// rtl/addertree_accum_if.sv - handshake bundle for addertree_accum (out_ovf present under ADDERTREE_ACC_OVF_EN)
interface addertree_accum_if #(
  parameter int N_IN   = 8,
  parameter int IN_BW  = 8,
  parameter int ACC_BW = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [N_IN*IN_BW-1:0] in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_BW-1:0]     out_data;
`ifdef ADDERTREE_ACC_OVF_EN
  logic                  out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
`else
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
`endif
endinterface

// File: rtl/addertree_accum.sv
// rtl/addertree_accum.sv - pipelined signed adder tree with group accumulator (optional ADDERTREE_ACC_OVF_EN)
module addertree_accum #(
  parameter int N_IN   = 8,
  parameter int IN_BW  = 8,
  parameter int ACC_BW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  addertree_accum_if.slave  bus
);
  localparam int LVL = $clog2(N_IN);
  localparam int TW  = IN_BW + LVL;

  logic                     adv;
  logic                     out_valid_q;
  logic signed [ACC_BW-1:0] out_data_q;
  logic signed [ACC_BW-1:0] acc_q;
  logic                     first_q;
  logic signed [ACC_BW-1:0] base;
  logic signed [ACC_BW-1:0] tree_ext;
  logic signed [ACC_BW-1:0] sum;
  logic signed [TW-1:0]     tree_sum;
  logic                     tree_vld;
  logic                     tree_lst;

  // the whole pipeline moves as one; it freezes only while a result waits
  assign adv           = ~out_valid_q | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  // stage 0 registers the beat; stage k holds N_IN>>k partial sums, one bit wider each level
  for (genvar k = 0; k <= LVL; k++) begin : g_stg
    localparam int W = IN_BW + k;
    localparam int N = N_IN >> k;

    logic signed [W-1:0] data [N];
    logic                vld;
    logic                lst;

    if (k == 0) begin : g_load
      // capture an accepted beat; a bubble enters when nothing is accepted
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld <= 1'b0;
          lst <= 1'b0;
          for (int j = 0; j < N; j++) data[j] <= '0;
        end else if (adv) begin
          vld <= bus.in_valid;
          lst <= bus.in_valid & bus.in_last;
          for (int j = 0; j < N; j++) data[j] <= bus.in_data[j*IN_BW +: IN_BW];
        end
      end
    end else begin : g_add
      // add sign-extended adjacent pairs from the previous level
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld <= 1'b0;
          lst <= 1'b0;
          for (int j = 0; j < N; j++) data[j] <= '0;
        end else if (adv) begin
          vld <= g_stg[k-1].vld;
          lst <= g_stg[k-1].lst;
          for (int j = 0; j < N; j++) begin
            data[j] <= {g_stg[k-1].data[2*j][W-2],   g_stg[k-1].data[2*j]}
                     + {g_stg[k-1].data[2*j+1][W-2], g_stg[k-1].data[2*j+1]};
          end
        end
      end
    end
  end

  assign tree_sum = g_stg[LVL].data[0];
  assign tree_vld = g_stg[LVL].vld;
  assign tree_lst = g_stg[LVL].lst;

  // first beat of a group starts from zero so no earlier group leaks in
  always_comb begin
    base     = first_q ? '0 : acc_q;
    tree_ext = ACC_BW'(tree_sum);
    sum      = base + tree_ext;
  end

  // accumulate tree sums; a last beat publishes the total and rearms the group
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (adv) begin
      out_valid_q <= 1'b0;
      if (tree_vld) begin
        if (tree_lst) begin
          out_data_q  <= sum;
          out_valid_q <= 1'b1;
          acc_q       <= '0;
          first_q     <= 1'b1;
        end else begin
          acc_q   <= sum;
          first_q <= 1'b0;
        end
      end
    end
  end

`ifdef ADDERTREE_ACC_OVF_EN
  logic step_ovf;
  logic ovf_acc_q;
  logic out_ovf_q;

  assign step_ovf    = (base[ACC_BW-1] == tree_ext[ACC_BW-1]) && (sum[ACC_BW-1] != base[ACC_BW-1]);
  assign bus.out_ovf = out_ovf_q;

  // sticky per-group overflow, published with the result and held with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_acc_q <= 1'b0;
      out_ovf_q <= 1'b0;
    end else if (adv && tree_vld) begin
      if (tree_lst) begin
        out_ovf_q <= ovf_acc_q | step_ovf;
        ovf_acc_q <= 1'b0;
      end else begin
        ovf_acc_q <= ovf_acc_q | step_ovf;
      end
    end
  end
`endif

endmodule

// File: tb/tb_addertree_accum.sv
// tb/tb_addertree_accum.sv - randomized self-checking bench for addertree_accum
module tb_addertree_accum;
  localparam int N_IN   = 8;
  localparam int IN_BW  = 8;
  localparam int ACC_BW = 32;
  localparam int LVL    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  addertree_accum_if #(.N_IN(N_IN), .IN_BW(IN_BW), .ACC_BW(ACC_BW)) bus ();
  addertree_accum #(.N_IN(N_IN), .IN_BW(IN_BW), .ACC_BW(ACC_BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef ADDERTREE_ACC_OVF_EN
  addertree_accum_if #(.N_IN(8), .IN_BW(8), .ACC_BW(12)) bus_s ();
  addertree_accum #(.N_IN(8), .IN_BW(8), .ACC_BW(12)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );
`endif

  // reference model: group arithmetic on plain integers
  logic signed [31:0] acc_m;
  bit                 first_m = 1'b1;
  bit                 ovf_m;
  logic signed [31:0] exp_q[$];
  bit                 exp_ovf_q[$];
  logic signed [31:0] got_q[$];
  bit                 got_ovf_q[$];

  // record every accepted result
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      got_q.push_back(bus.out_data);
`ifdef ADDERTREE_ACC_OVF_EN
      got_ovf_q.push_back(bus.out_ovf);
`else
      got_ovf_q.push_back(1'b0);
`endif
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic longint beat_sum(input logic [63:0] d);
    longint s = 0;
    for (int i = 0; i < 8; i++) begin
      logic signed [7:0] e;
      e = d[i*8 +: 8];
      s += longint'(e);
    end
    return s;
  endfunction

  function automatic logic [63:0] fill(input logic [7:0] v);
    return {8{v}};
  endfunction

  function automatic logic [63:0] ramp();
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'(i);
    return d;
  endfunction

  function automatic logic [63:0] rnd_beat();
    return {$urandom(), $urandom()};
  endfunction

  task automatic model_clear();
    first_m = 1'b1;
    acc_m   = '0;
    ovf_m   = 1'b0;
    exp_q.delete();
    exp_ovf_q.delete();
    got_q.delete();
    got_ovf_q.delete();
  endtask

  task automatic model_beat(input logic [63:0] d, input bit last);
    longint s;
    if (first_m) ovf_m = 1'b0;
    s = (first_m ? 64'sd0 : longint'(acc_m)) + beat_sum(d);
    if (s > 64'sd2147483647 || s < -64'sd2147483648) ovf_m = 1'b1;
    acc_m = s[31:0];
    if (last) begin
      exp_q.push_back(acc_m);
      exp_ovf_q.push_back(ovf_m);
      first_m = 1'b1;
    end else begin
      first_m = 1'b0;
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input bit last);
    int w = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout in_ready=%0b required=1", bus.in_ready);
    end else begin
      model_beat(d, last);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int c = 0;
    while (got_q.size() < n && c < 400) begin
      @(posedge clk);
      c++;
    end
    repeat (LVL + 4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
    total++;
    if (bus.out_data !== 32'd0) begin bad++; $display("FAIL reset_out_data got=%0d exp=0", bus.out_data); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_latency();
    model_clear();
    send_beat(fill(8'd1), 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (bus.out_valid !== (i == 4)) begin
        bad++;
        $display("FAIL latency_edge%0d out_valid got=%0b exp=%0b", i, bus.out_valid, (i == 4));
      end
    end
    total++;
    if ($signed(bus.out_data) !== 32'sd8) begin bad++; $display("FAIL single_data got=%0d exp=8", $signed(bus.out_data)); end
    wait_results(1);
    total++;
    if (got_q.size() != 1) begin bad++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
  endtask

  task automatic test_neg128();
    model_clear();
    for (int b = 0; b < 4; b++) send_beat(fill(8'h80), b == 3);
    wait_results(1);
    total++;
    if (got_q.size() != 1) begin
      bad++;
      $display("FAIL neg128_count got=%0d exp=1", got_q.size());
    end else begin
      total++;
      if (got_q[0] !== 32'shFFFFF000) begin bad++; $display("FAIL neg128_data got=%0d exp=-4096", got_q[0]); end
    end
  endtask

  task automatic test_back_to_back();
    model_clear();
    send_beat(fill(8'd3), 1'b1);
    send_beat(ramp(), 1'b0);
    send_beat(ramp(), 1'b1);
    wait_results(2);
    total++;
    if (got_q.size() != 2) begin
      bad++;
      $display("FAIL b2b_count got=%0d exp=2", got_q.size());
    end else begin
      total++;
      if (got_q[0] !== 32'sd24) begin bad++; $display("FAIL b2b_first got=%0d exp=24", got_q[0]); end
      total++;
      if (got_q[1] !== 32'sd56) begin bad++; $display("FAIL b2b_second got=%0d exp=56", got_q[1]); end
    end
  endtask

  task automatic test_backpressure();
    int c = 0;
    model_clear();
    bus.out_ready = 1'b0;
    send_beat(rnd_beat(), 1'b1);
    while (!bus.out_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_first_valid got=%0b exp=1", bus.out_valid); end
    fork
      begin
        send_beat(rnd_beat(), 1'b0);
        send_beat(rnd_beat(), 1'b1);
        send_beat(rnd_beat(), 1'b1);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          total++;
          if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid cyc=%0d got=%0b exp=1", i, bus.out_valid); end
          total++;
          if ($signed(bus.out_data) !== exp_q[0]) begin bad++; $display("FAIL bp_hold_data cyc=%0d got=%0d exp=%0d", i, $signed(bus.out_data), exp_q[0]); end
          total++;
          if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%0b exp=0", i, bus.in_ready); end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_results(3);
    total++;
    if (got_q.size() != 3) begin
      bad++;
      $display("FAIL bp_count got=%0d exp=3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_order idx=%0d got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_random();
    bit done = 1'b0;
    model_clear();
    fork
      begin
        for (int g = 0; g < 12; g++) begin
          int nb = $urandom_range(1, 5);
          for (int b = 0; b < nb; b++) begin
            send_beat(rnd_beat(), b == nb - 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_results(exp_q.size());
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_data idx=%0d got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
`ifdef ADDERTREE_ACC_OVF_EN
        total++;
        if (got_ovf_q[i] !== exp_ovf_q[i]) begin bad++; $display("FAIL rand_ovf idx=%0d got=%0b exp=%0b", i, got_ovf_q[i], exp_ovf_q[i]); end
`endif
      end
    end
  endtask

  task automatic test_reset_mid();
    model_clear();
    bus.out_ready = 1'b1;
    send_beat(ramp(), 1'b0);
    send_beat(fill(8'd5), 1'b0);
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%0b exp=0", bus.out_valid); end
    total++;
    if (bus.out_data !== 32'd0) begin bad++; $display("FAIL rstmid_data got=%0d exp=0", bus.out_data); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    repeat (LVL + 3) @(posedge clk);
    #1;
    total++;
    if (got_q.size() != 0) begin bad++; $display("FAIL rstmid_ghost got=%0d exp=0", got_q.size()); end
    send_beat(fill(8'd2), 1'b1);
    wait_results(1);
    total++;
    if (got_q.size() != 1) begin
      bad++;
      $display("FAIL rstmid_count got=%0d exp=1", got_q.size());
    end else begin
      total++;
      if (got_q[0] !== 32'sd16) begin bad++; $display("FAIL rstmid_after got=%0d exp=16", got_q[0]); end
    end
  endtask

`ifdef ADDERTREE_ACC_OVF_EN
  task automatic test_ovf();
    int c = 0;
    bus_s.out_ready = 1'b1;
    for (int b = 0; b < 17; b++) begin
      bus_s.in_valid = 1'b1;
      bus_s.in_data  = fill(8'd127);
      bus_s.in_last  = (b == 16);
      @(posedge clk);
      #1;
    end
    bus_s.in_valid = 1'b0;
    bus_s.in_last  = 1'b0;
    while (!bus_s.out_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    total++;
    if ($signed(bus_s.out_data) !== 12'sd888) begin bad++; $display("FAIL ovf_wrap_data got=%0d exp=888", $signed(bus_s.out_data)); end
    total++;
    if (bus_s.out_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag_set got=%0b exp=1", bus_s.out_ovf); end
    @(posedge clk);
    #1;
    bus_s.in_valid = 1'b1;
    bus_s.in_data  = fill(8'd1);
    bus_s.in_last  = 1'b1;
    @(posedge clk);
    #1;
    bus_s.in_valid = 1'b0;
    bus_s.in_last  = 1'b0;
    c = 0;
    while (!bus_s.out_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    total++;
    if ($signed(bus_s.out_data) !== 12'sd8) begin bad++; $display("FAIL ovf_next_data got=%0d exp=8", $signed(bus_s.out_data)); end
    total++;
    if (bus_s.out_ovf !== 1'b0) begin bad++; $display("FAIL ovf_flag_clear got=%0b exp=0", bus_s.out_ovf); end
  endtask
`endif

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
`ifdef ADDERTREE_ACC_OVF_EN
    bus_s.in_valid  = 1'b0;
    bus_s.in_data   = '0;
    bus_s.in_last   = 1'b0;
    bus_s.out_ready = 1'b1;
`endif
    test_reset();
    test_single_latency();
    test_neg128();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef ADDERTREE_ACC_OVF_EN
    test_ovf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
